// File: rtl/clm_mixcol_sched_pkg.sv
// Shared types for the CLM MixColumns scheduler: encoded byte, refresh word,
// encoded column and the scheduler state encoding.
package clm_mixcol_sched_pkg;

  // Redundancy length of the code; an encoded byte carries 8 data bits on top
  // of D redundancy bits, and a refresh word is D bits wide.
  localparam int D = 1;
  localparam int W = 8 + D;

  typedef logic [W-1:0] state_t;
  typedef logic [D-1:0] red_poly_t;

  // Element i is byte i of the column.
  typedef state_t [3:0] column_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    COMB,
    OUT
  } sched_state_e;

endpackage

// File: rtl/clm_mixcol_sched_xor.sv
// Combinational output network of the scheduler. With dbl[i] = 2*a[i] in the
// encoded domain, out[i] = 2a[i] ^ 3a[i+1] ^ a[i+2] ^ a[i+3]; the encoding is
// linear, so the combination can be applied directly to the encoded words.
module clm_mixcol_xor
  import clm_mixcol_sched_pkg::*;
(
  input  column_t col,
  input  column_t dbl,
  output column_t mix
);

  // Each output byte: its own doubled byte, the next doubled byte (which
  // together with the plain next byte yields 3*a[i+1]) and the other bytes.
  assign mix[0] = dbl[0] ^ dbl[1] ^ col[1] ^ col[2] ^ col[3];
  assign mix[1] = dbl[1] ^ dbl[2] ^ col[2] ^ col[3] ^ col[0];
  assign mix[2] = dbl[2] ^ dbl[3] ^ col[3] ^ col[0] ^ col[1];
  assign mix[3] = dbl[3] ^ dbl[0] ^ col[0] ^ col[1] ^ col[2];

endmodule

// File: rtl/clm_mixcol_sched.sv
// Sequences one AES MixColumns on a CLM-encoded column through a single
// external L(2) multiply-and-reduce datapath, one byte per consumed refresh
// word, then forms the result with an XOR network on the encoded words.
module clm_mixcol_sched
  import clm_mixcol_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  column_t   col_in,
  input  logic      col_valid,
  output logic      col_ready,
  input  red_poly_t rnd_in,
  input  logic      rnd_valid,
  output logic      rnd_ready,
  output state_t    mul_in,
  output red_poly_t mul_r,
  input  state_t    mul_out,
  output column_t   col_out,
  output logic      out_valid,
  input  logic      out_ready,
  output logic      busy
);

  sched_state_e state;
  logic [1:0]   k;
  column_t      col_reg;
  column_t      dbl_reg;
  column_t      mix;

  clm_mixcol_xor u_xor (
    .col (col_reg),
    .dbl (dbl_reg),
    .mix (mix)
  );

  // Multiplier operands are presented only while multiplying, so no share
  // residue reaches the datapath in any other state.
  // NOTE: every output gets a default before the branch; a path that leaves
  // a combinational output unassigned would infer a latch.
  always_comb begin
    mul_in = '0;
    mul_r  = '0;
    if (state == MUL) begin
      mul_in = col_reg[k];
      mul_r  = rnd_in;
    end
  end

  // Scheduler FSM with registered handshake/status outputs and datapath
  // registers; k advances only when a refresh word is consumed.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge; blocking here would create
  // order-dependent simulation and a synthesis/simulation mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      col_ready <= 1'b1;
      rnd_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      col_out   <= '0;
      // NOTE: the column and doubled-byte arrays are reset on purpose so a
      // reset mid-operation discards any partially computed shares.
      col_reg   <= '0;
      dbl_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (col_valid && col_ready) begin
            col_reg   <= col_in;
            k         <= '0;
            state     <= MUL;
            col_ready <= 1'b0;
            rnd_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        MUL: begin
          if (rnd_valid) begin
            dbl_reg[k] <= mul_out;
            k          <= k + 2'd1;
            if (k == 2'd3) begin
              state     <= COMB;
              rnd_ready <= 1'b0;
            end
          end
        end
        COMB: begin
          col_out   <= mix;
          state     <= OUT;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            col_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          col_ready <= 1'b1;
          rnd_ready <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clm_mixcol_sched.sv
// Self-checking bench for clm_mixcol_sched. The external multiplier is
// modelled here as either an identity stub or an L(2) stand-in (xtime on the
// data bits, linear parity-plus-refresh on the redundancy bit). Results are
// checked against AES MixColumns on the decoded data bytes and against the
// linear encoded-domain combination of the recorded multiplier results.
module tb_clm_mixcol_sched;
  import clm_mixcol_sched_pkg::*;

  logic      clk;
  logic      rst_n;
  column_t   col_in;
  logic      col_valid;
  logic      col_ready;
  red_poly_t rnd_in;
  logic      rnd_valid;
  logic      rnd_ready;
  state_t    mul_in;
  red_poly_t mul_r;
  state_t    mul_out;
  column_t   col_out;
  logic      out_valid;
  logic      out_ready;
  logic      busy;

  logic      real_mul;
  logic      zero_rnd;
  int        checks;
  int        errors;

  clm_mixcol_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .mul_in    (mul_in),
    .mul_r     (mul_r),
    .mul_out   (mul_out),
    .col_out   (col_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Stand-in L(2) multiplier: doubles the data byte, keeps the output a
  // codeword (plus refresh) when the input is one; linear in (x, r).
  function automatic state_t mul_l2(input state_t x, input red_poly_t r);
    logic [7:0] b;
    logic [7:0] t;
    b = x[W-1:D];
    t = xtime(b);
    return {t, red_poly_t'(^t ^ ^b) ^ x[D-1:0] ^ r};
  endfunction

  always_comb mul_out = real_mul ? mul_l2(mul_in, mul_r) : mul_in;

  function automatic column_t mk_col(input logic [31:0] bytes, input logic enc);
    column_t c;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = bytes[31-8*i -: 8];
      c[i] = {b, enc ? red_poly_t'(^b) : red_poly_t'(0)};
    end
    return c;
  endfunction

  function automatic logic [31:0] decode_col(input column_t c);
    return {c[0][W-1:D], c[1][W-1:D], c[2][W-1:D], c[3][W-1:D]};
  endfunction

  // Plain AES MixColumns on four data bytes, byte 0 in the top octet.
  function automatic logic [31:0] mixcol(input logic [31:0] a);
    logic [7:0]  b [4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) b[i] = a[31-8*i -: 8];
    for (int i = 0; i < 4; i++)
      o[31-8*i -: 8] = xtime(b[i]) ^ xtime(b[(i+1)%4]) ^ b[(i+1)%4]
                       ^ b[(i+2)%4] ^ b[(i+3)%4];
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a column and wait (bounded) for the handshake edge t0.
  task automatic start_col(input column_t c);
    int n;
    col_in    = c;
    col_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!col_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("col_ready_wait", col_ready, 1);
    @(posedge clk);
    #1 col_valid = 1'b0;
  endtask

  // Drive refresh words until the result appears; lat is the cycle index
  // (edge t0+lat) at which downstream first samples out_valid high.
  task automatic mul_phase(input column_t c, input int stall, output column_t res,
                           output int lat);
    state_t  dbl [4];
    int      k;
    column_t exp;
    k   = 0;
    lat = -1;
    for (int i = 0; i < 4; i++) dbl[i] = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      rnd_valid = (stall == 0) || (cyc % stall == 0);
      rnd_in    = zero_rnd ? red_poly_t'(0) : red_poly_t'($urandom);
      @(negedge clk);
      if (out_valid) begin
        lat = cyc;
        break;
      end
      if (rnd_ready && k < 4) begin
        check("mul_in", mul_in, c[2'(k)]);
        check("mul_r", mul_r, rnd_in);
        if (rnd_valid) begin
          dbl[k] = real_mul ? mul_l2(c[2'(k)], rnd_in) : c[2'(k)];
          k++;
        end
      end else if (!rnd_ready) begin
        check("mul_in_idle", mul_in, 0);
        check("mul_r_idle", mul_r, 0);
      end else begin
        k++;
      end
      @(posedge clk);
      #1;
    end
    rnd_valid = 1'b0;
    check("rnd_handshakes", k, 4);
    check("result_seen", lat > 0, 1);
    for (int i = 0; i < 4; i++)
      exp[i] = dbl[i] ^ dbl[(i+1)%4] ^ c[2'((i+1)%4)] ^ c[2'((i+2)%4)] ^ c[2'((i+3)%4)];
    res = col_out;
    check("col_out_encoded", col_out, exp);
    if (lat > 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("rel_out_valid", out_valid, 0);
    check("rel_col_ready", col_ready, 1);
    check("rel_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    column_t     col;
    logic        use_mul;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [3];

  initial begin
    column_t     res;
    column_t     ref_res;
    column_t     c;
    int          lat;
    checks    = 0;
    errors    = 0;
    real_mul  = 1'b0;
    zero_rnd  = 1'b1;
    col_in    = '0;
    col_valid = 1'b0;
    rnd_in    = red_poly_t'(1);
    rnd_valid = 1'b1;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    vecs[0] = '{col: mk_col(32'h01020408, 1'b0), use_mul: 1'b0, exp: 32'h0d0b070e};
    vecs[1] = '{col: mk_col(32'hdb135345, 1'b1), use_mul: 1'b1, exp: 32'h8e4da1bc};
    vecs[2] = '{col: mk_col(32'hf20a225c, 1'b1), use_mul: 1'b1, exp: 32'h9fdc589d};

    // Reset state, with refresh valid and nonzero to show it is ignored.
    #12;
    check("rst_col_ready", col_ready, 1);
    check("rst_rnd_ready", rnd_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_col_out", col_out, 0);
    check("rst_mul_in", mul_in, 0);
    check("rst_mul_r", mul_r, 0);
    rst_n     = 1'b1;
    rnd_valid = 1'b0;
    @(posedge clk);
    #1;

    // Golden vectors, unstalled: latency and decoded result.
    for (int v = 0; v < 3; v++) begin
      real_mul = vecs[v].use_mul;
      start_col(vecs[v].col);
      mul_phase(vecs[v].col, 0, res, lat);
      check("latency", lat, 6);
      check("golden_decoded", decode_col(res), vecs[v].exp);
      if (v == 2) ref_res = res;
      release_out();
    end

    // Refresh every third cycle: same result as the unstalled run.
    real_mul = 1'b1;
    start_col(vecs[2].col);
    mul_phase(vecs[2].col, 3, res, lat);
    check("stall_same_result", res, ref_res);
    release_out();

    // Downstream back-pressure with a second column waiting.
    zero_rnd = 1'b0;
    c = mk_col(32'h455313db, 1'b1);
    start_col(vecs[1].col);
    mul_phase(vecs[1].col, 0, res, lat);
    col_in    = c;
    col_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_col_out", col_out, res);
      check("hold_out_valid", out_valid, 1);
      check("hold_col_ready", col_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold_ready_rises", col_ready, 1);
    check("hold_not_busy", busy, 0);
    @(posedge clk);
    #1 col_valid = 1'b0;
    @(negedge clk);
    check("second_accepted", busy, 1);
    @(posedge clk);
    #1;
    // One MUL cycle already elapsed with rnd_valid low; continue from there.
    mul_phase(c, 0, res, lat);
    check("second_decoded", decode_col(res), mixcol(32'h455313db));
    release_out();

    // Reset while k == 2, then a clean column.
    start_col(vecs[1].col);
    rnd_valid = 1'b1;
    rnd_in    = red_poly_t'(1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_k2_mul_in", mul_in, vecs[1].col[2]);
    rst_n = 1'b0;
    #1;
    check("mid_rst_col_ready", col_ready, 1);
    check("mid_rst_mul_in", mul_in, 0);
    check("mid_rst_mul_r", mul_r, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rnd_ready", rnd_ready, 0);
    #3 rst_n  = 1'b1;
    rnd_valid = 1'b0;
    @(posedge clk);
    #1;
    start_col(vecs[2].col);
    mul_phase(vecs[2].col, 0, res, lat);
    check("post_rst_decoded", decode_col(res), vecs[2].exp);
    release_out();

    // Random columns, random refresh and random stall patterns.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 4; i++) c[i] = state_t'($urandom);
      start_col(c);
      mul_phase(c, int'($urandom_range(0, 3)), res, lat);
      check("rand_decoded", decode_col(res), mixcol(decode_col(c)));
      release_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clm_mixcol_sched.md
Name: clm_mixcol_sched

Overview:
- Sequences one AES MixColumns on a CLM-encoded column (4 encoded bytes) using a single shared L(2)-multiply-and-reduce datapath instance, time-multiplexed over four operations.
- The block feeds each byte with one fresh refresh word. It captures the four doubled bytes and forms the outputs with linear XOR combinations on the encoded words; the encoding is linear.
- It sits between the round controller (column handshake) and the randomness source (refresh handshake), inside the masked AES round.

Parameters:
- d, 1, redundancy length of the code; an encoded byte is 8+d bits and a refresh word is d bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- col_in  input  4x(8+d)  encoded column, byte 0 first
- col_valid  input  1  column present
- col_ready  output  1  block can accept a column
- rnd_in  input  d  refresh word
- rnd_valid  input  1  refresh word present
- rnd_ready  output  1  block consumes rnd_in this cycle
- mul_in  output  8+d  operand to the shared multiplier
- mul_r  output  d  refresh to the shared multiplier
- mul_out  input  8+d  multiplier result (combinational, same cycle)
- col_out  output  4x(8+d)  encoded MixColumns result
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n=0) state:
  - state=IDLE, k=0.
  - col_ready=1, rnd_ready=0, out_valid=0, busy=0.
  - col_out, mul_in, mul_r all zero.
  - Internal registers col_reg[0:3] and dbl_reg[0:3] cleared.
- IDLE:
  - col_ready=1.
  - On col_valid&&col_ready, latch col_in into col_reg, set k=0, go to MUL.
- MUL:
  - col_ready=0, rnd_ready=1.
  - mul_in=col_reg[k], mul_r=rnd_in.
  - On rnd_valid: dbl_reg[k]<=mul_out and k<=k+1. If k==3, go to COMB.
  - Without rnd_valid: stall and hold k. No multiplier result is captured without a consumed refresh word.
  - Each refresh word is used exactly once.
- COMB:
  - One cycle, rnd_ready=0.
  - For i=0..3, indices mod 4: col_out[i] <= dbl[i] ^ dbl[i+1] ^ col_reg[i+1] ^ col_reg[i+2] ^ col_reg[i+3].
  - Then go to OUT.
- OUT:
  - out_valid=1; col_out held stable until accepted.
  - On out_ready: go to IDLE, out_valid=0.
  - No new column is accepted in the same cycle.
- Latency with rnd_valid held high:
  - Handshake at edge t0.
  - MUL captures at t0+1..t0+4.
  - COMB at t0+5.
  - out_valid asserted from t0+6.
  - Throughput: one column per 7 cycles.
- mul_in and mul_r outputs are zero outside MUL, so no residual share is presented to the datapath.
- Boundaries:
  - col_valid in non-IDLE states: ignored, col_ready=0.
  - rnd_valid outside MUL: ignored, not consumed.
  - out_ready low: hold indefinitely.
  - k wraps only by leaving MUL; k never exceeds 3.
  - Reset mid-operation: immediate return to reset state. Partial dbl_reg content is discarded and cleared.
- No arithmetic beyond XOR. All widths are 8+d with no truncation.

Decomposition:
- Shared package (types): state_t (8+d), red_poly_t (d), column_t (array of 4 state_t), and sched_state_e {IDLE, MUL, COMB, OUT}.
- The multiplier stays external, with its L and B_ext_MC matrices wired at top level.
- One sub-module is natural: clm_mixcol_xor, the purely combinational COMB network.

Test Plan:
- Identity stub (mul_out=mul_in), col_in={01,02,04,08} (redundancy 0), rnd_valid=1 -> col_out={0d,0b,07,0e} per out_i=a_i^a_(i+2)^a_(i+3); out_valid at t0+6.
- Real mul_L2, zero refresh, column db 13 53 45 encoded -> golden-decoded col_out = 8e 4d a1 bc; also f2 0a 22 5c -> 9f dc 58 9d.
- rnd_valid pulsed every 3rd cycle -> exactly 4 rnd handshakes, mul_in steps col_reg[0..3] only on consumption; result identical to the unstalled run.
- Random refresh words, 1000 random columns vs golden model (decode(col_out) == MixColumns(decode(col_in))) -> zero mismatches; mul_r equals consumed rnd_in each step.
- out_ready held low 20 cycles, col_valid high throughout -> col_out stable, col_ready=0, no second column accepted; accepted on the first cycle col_ready rises.
- rst_n asserted during MUL at k=2 -> immediately IDLE, col_ready=1, mul_in=0, busy=0; the next column completes correctly.
